// File: rtl/axis_fmcw_chirp_sequencer.sv
// Frame sequencer for the FMCW receive chain: ramp trigger generation, chirp counting,
// frame-stable window config and sticky error collection from the window stream.
module axis_fmcw_chirp_sequencer #(
  parameter int unsigned PERIOD_WIDTH = 32,
  parameter int unsigned CHIRP_WIDTH  = 16,
  parameter int unsigned RAMP_LEN     = 50
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    start,
  input  logic                    stop,
  input  logic [PERIOD_WIDTH-1:0] cfg_period,
  input  logic [CHIRP_WIDTH-1:0]  cfg_nchirp,
  input  logic [7:0]              cfg_window,
  input  logic                    win_err_nsmall,
  input  logic                    win_err_overskip,
  input  logic                    mon_tvalid,
  input  logic                    mon_tready,
  input  logic                    mon_tlast,
  output logic                    ramp,
  output logic [7:0]              win_cfg,
  output logic                    busy,
  output logic                    frame_done,
  output logic [CHIRP_WIDTH-1:0]  chirp_cnt,
  output logic [3:0]              sts_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [CHIRP_WIDTH-1:0]  nchirp_q, nchirp_d;
  logic [CHIRP_WIDTH-1:0]  chirp_cnt_q, chirp_cnt_d;
  logic [7:0]              win_cfg_q, win_cfg_d;
  logic [3:0]              sts_err_q, sts_err_d;
  logic                    pending_q, pending_d;
  logic                    ramp_q, ramp_d;
  logic                    busy_q, busy_d;
  logic                    frame_done_q, frame_done_d;

  logic tlast_hs;
  logic cnt_last;
  logic cfg_ok;

  assign tlast_hs = mon_tvalid & mon_tready & mon_tlast;
  assign cnt_last = (cnt_q == period_q - PERIOD_WIDTH'(1));
  assign cfg_ok   = (cfg_period > PERIOD_WIDTH'(RAMP_LEN)) && (cfg_nchirp != CHIRP_WIDTH'(0));

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    nchirp_d    = nchirp_q;
    chirp_cnt_d = chirp_cnt_q;
    win_cfg_d   = win_cfg_q;
    sts_err_d   = sts_err_q;
    pending_d   = pending_q;
    ramp_d      = 1'b0;

    if (tlast_hs) pending_d = 1'b0;

    if (state_q == S_IDLE) begin
      cnt_d = '0;
      if (!stop && start) begin
        if (cfg_ok) state_d = S_LOAD;
        else        sts_err_d[3] = 1'b1;
      end
    end else if (stop) begin
      // Abort: counters and status freeze for the PS to read back
      state_d   = S_IDLE;
      cnt_d     = '0;
      pending_d = pending_q;
    end else begin
      sts_err_d[0] = sts_err_q[0] | win_err_nsmall;
      sts_err_d[1] = sts_err_q[1] | win_err_overskip;
      case (state_q)
        S_LOAD: begin
          win_cfg_d   = cfg_window;
          period_d    = cfg_period;
          nchirp_d    = cfg_nchirp;
          chirp_cnt_d = '0;
          sts_err_d   = '0;
          pending_d   = 1'b0;
          cnt_d       = '0;
          state_d     = S_RUN;
        end
        S_RUN: begin
          ramp_d = (cnt_q < PERIOD_WIDTH'(RAMP_LEN));
          // A new chirp while the previous tlast is still outstanding is a miss
          if (cnt_q == '0) begin
            if (pending_q && !tlast_hs) sts_err_d[2] = 1'b1;
            pending_d = 1'b1;
          end
          if (cnt_last) begin
            chirp_cnt_d = chirp_cnt_q + CHIRP_WIDTH'(1);
            cnt_d       = '0;
            if (chirp_cnt_q + CHIRP_WIDTH'(1) == nchirp_q) state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + PERIOD_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (!pending_q || tlast_hs) begin
            state_d = S_DONE;
          end else if (cnt_last) begin
            sts_err_d[2] = 1'b1;
            state_d      = S_DONE;
          end else begin
            cnt_d = cnt_q + PERIOD_WIDTH'(1);
          end
        end
        S_DONE: begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d       = (state_d != S_IDLE);
    frame_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      period_q     <= '0;
      nchirp_q     <= '0;
      chirp_cnt_q  <= '0;
      win_cfg_q    <= '0;
      sts_err_q    <= '0;
      pending_q    <= 1'b0;
      ramp_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      nchirp_q     <= nchirp_d;
      chirp_cnt_q  <= chirp_cnt_d;
      win_cfg_q    <= win_cfg_d;
      sts_err_q    <= sts_err_d;
      pending_q    <= pending_d;
      ramp_q       <= ramp_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ramp       = ramp_q;
  assign win_cfg    = win_cfg_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign chirp_cnt  = chirp_cnt_q;
  assign sts_err    = sts_err_q;

endmodule

// File: tb/tb_axis_fmcw_chirp_sequencer.sv
// Directed bench for axis_fmcw_chirp_sequencer with RAMP_LEN=4; edge numbers are counted
// from reset release, with the start request sampled at edge 1.
module tb_axis_fmcw_chirp_sequencer;

  localparam int unsigned PW = 32;
  localparam int unsigned CW = 16;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0, stop = 1'b0;
  logic [PW-1:0] cfg_period = '0;
  logic [CW-1:0] cfg_nchirp = '0;
  logic [7:0]    cfg_window = '0;
  logic          win_err_nsmall = 1'b0, win_err_overskip = 1'b0;
  logic          mon_tvalid = 1'b0, mon_tready = 1'b0, mon_tlast = 1'b0;
  logic          ramp, busy, frame_done;
  logic [7:0]    win_cfg;
  logic [CW-1:0] chirp_cnt;
  logic [3:0]    sts_err;

  int n_cmp = 0;
  int n_err = 0;

  // Observation record, refreshed every sampled edge
  int   edge_n;
  int   rises[$];
  int   fds[$];
  int   busy_fall;
  int   err2_at;
  int   ramp_hi;
  int   wcfg_bad;
  logic ramp_prev, busy_prev, err2_prev;
  logic [7:0] wcfg_exp;
  bit   wcfg_chk;

  always #5 aclk = ~aclk;

  axis_fmcw_chirp_sequencer #(
    .PERIOD_WIDTH(PW),
    .CHIRP_WIDTH (CW),
    .RAMP_LEN    (4)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .start           (start),
    .stop            (stop),
    .cfg_period      (cfg_period),
    .cfg_nchirp      (cfg_nchirp),
    .cfg_window      (cfg_window),
    .win_err_nsmall  (win_err_nsmall),
    .win_err_overskip(win_err_overskip),
    .mon_tvalid      (mon_tvalid),
    .mon_tready      (mon_tready),
    .mon_tlast       (mon_tlast),
    .ramp            (ramp),
    .win_cfg         (win_cfg),
    .busy            (busy),
    .frame_done      (frame_done),
    .chirp_cnt       (chirp_cnt),
    .sts_err         (sts_err)
  );

  task automatic clear_obs();
    edge_n = 0;
    rises.delete();
    fds.delete();
    busy_fall = -1;
    err2_at   = -1;
    ramp_hi   = 0;
    wcfg_bad  = 0;
    wcfg_chk  = 1'b0;
    ramp_prev = ramp;
    busy_prev = busy;
    err2_prev = sts_err[2];
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
    edge_n++;
    if (ramp && !ramp_prev) rises.push_back(edge_n);
    if (ramp) ramp_hi++;
    if (frame_done) fds.push_back(edge_n);
    if (!busy && busy_prev && busy_fall < 0) busy_fall = edge_n;
    if (sts_err[2] && !err2_prev && err2_at < 0) err2_at = edge_n;
    if (wcfg_chk && busy && win_cfg !== wcfg_exp) wcfg_bad++;
    ramp_prev = ramp;
    busy_prev = busy;
    err2_prev = sts_err[2];
  endtask

  function automatic int rise_at(int i);
    return (i < rises.size()) ? rises[i] : -1;
  endfunction

  function automatic int fd_at(int i);
    return (i < fds.size()) ? fds[i] : -1;
  endfunction

  task automatic do_reset();
    aresetn = 1'b0;
    start = 1'b0; stop = 1'b0;
    cfg_period = '0; cfg_nchirp = '0; cfg_window = '0;
    win_err_nsmall = 1'b0; win_err_overskip = 1'b0;
    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    clear_obs();
  endtask

  task automatic set_hs(input bit v);
    mon_tvalid = v; mon_tready = v; mon_tlast = v;
  endtask

  // Starts a period=20, nchirp=3 frame at edge 1 and runs to last_edge with tlast at the given edges
  task automatic run_frame(input int hs0, input int hs1, input int hs2, input int last_edge);
    cfg_period = 32'd20; cfg_nchirp = 16'd3;
    start = 1'b1;
    step();
    for (int e = 2; e <= last_edge; e++) begin
      start = (e <= 10);
      set_hs(e == hs0 || e == hs1 || e == hs2);
      step();
    end
    set_hs(1'b0);
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({ramp, busy, frame_done} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b expected 000", {ramp, busy, frame_done});
    end
    n_cmp++;
    if (win_cfg !== 8'h00 || chirp_cnt !== 16'd0 || sts_err !== 4'h0) begin
      n_err++; $display("FAIL reset_regs: got win_cfg=%h chirp_cnt=%0d sts_err=%b expected 00/0/0000",
                        win_cfg, chirp_cnt, sts_err);
    end
  endtask

  task automatic test_nominal();
    do_reset();
    run_frame(13, 33, 53, 70);
    n_cmp++;
    if (rises.size() !== 3 || rise_at(0) !== 3 || rise_at(1) !== 23 || rise_at(2) !== 43) begin
      n_err++; $display("FAIL nom_rises: got n=%0d at %0d,%0d,%0d expected 3 at 3,23,43",
                        rises.size(), rise_at(0), rise_at(1), rise_at(2));
    end
    n_cmp++;
    if (ramp_hi !== 12) begin
      n_err++; $display("FAIL nom_ramp_width: got %0d high cycles expected 12", ramp_hi);
    end
    n_cmp++;
    if (fds.size() !== 1 || fd_at(0) !== 63) begin
      n_err++; $display("FAIL nom_frame_done: got n=%0d at %0d expected 1 at 63", fds.size(), fd_at(0));
    end
    n_cmp++;
    if (busy_fall !== 64) begin
      n_err++; $display("FAIL nom_busy_fall: got %0d expected 64", busy_fall);
    end
    n_cmp++;
    if (chirp_cnt !== 16'd3 || sts_err !== 4'b0000) begin
      n_err++; $display("FAIL nom_status: got chirp_cnt=%0d sts_err=%b expected 3/0000", chirp_cnt, sts_err);
    end
  endtask

  task automatic test_missed_tlast();
    do_reset();
    run_frame(0, 33, 53, 70);
    n_cmp++;
    if (err2_at !== 23) begin
      n_err++; $display("FAIL miss_err_edge: got %0d expected 23", err2_at);
    end
    n_cmp++;
    if (rises.size() !== 3 || fd_at(0) !== 63) begin
      n_err++; $display("FAIL miss_continue: got rises=%0d frame_done at %0d expected 3/63", rises.size(), fd_at(0));
    end
    n_cmp++;
    if (chirp_cnt !== 16'd3 || sts_err !== 4'b0100) begin
      n_err++; $display("FAIL miss_status: got chirp_cnt=%0d sts_err=%b expected 3/0100", chirp_cnt, sts_err);
    end
  endtask

  task automatic test_drain_timeout();
    do_reset();
    run_frame(13, 33, 0, 90);
    n_cmp++;
    if (fds.size() !== 1 || fd_at(0) !== 82) begin
      n_err++; $display("FAIL drain_frame_done: got n=%0d at %0d expected 1 at 82", fds.size(), fd_at(0));
    end
    n_cmp++;
    if (err2_at !== 82 || sts_err !== 4'b0100) begin
      n_err++; $display("FAIL drain_err: got edge %0d sts_err=%b expected 82/0100", err2_at, sts_err);
    end
    n_cmp++;
    if (busy_fall !== 83 || chirp_cnt !== 16'd3) begin
      n_err++; $display("FAIL drain_end: got busy_fall=%0d chirp_cnt=%0d expected 83/3", busy_fall, chirp_cnt);
    end
  endtask

  task automatic test_bad_cfg();
    do_reset();
    stop = 1'b1; start = 1'b1; cfg_period = 32'd4; cfg_nchirp = 16'd3;
    step();
    n_cmp++;
    if (sts_err !== 4'b0000 || busy !== 1'b0) begin
      n_err++; $display("FAIL bad_stop_prio: got sts_err=%b busy=%b expected 0000/0", sts_err, busy);
    end
    stop = 1'b0;
    step();
    n_cmp++;
    if (sts_err !== 4'b1000 || busy !== 1'b0) begin
      n_err++; $display("FAIL bad_period: got sts_err=%b busy=%b expected 1000/0", sts_err, busy);
    end
    cfg_period = 32'd20; cfg_nchirp = 16'd0;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    n_cmp++;
    if (sts_err !== 4'b1000 || busy !== 1'b0 || rises.size() !== 0) begin
      n_err++; $display("FAIL bad_nchirp: got sts_err=%b busy=%b rises=%0d expected 1000/0/0",
                        sts_err, busy, rises.size());
    end
    cfg_nchirp = 16'd3; start = 1'b1;
    step();
    start = 1'b0;
    step();
    n_cmp++;
    if (sts_err !== 4'b0000 || busy !== 1'b1) begin
      n_err++; $display("FAIL bad_clear_on_load: got sts_err=%b busy=%b expected 0000/1", sts_err, busy);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_cfg_hold();
    do_reset();
    cfg_window = 8'h8A; cfg_period = 32'd20; cfg_nchirp = 16'd3;
    wcfg_exp = 8'h8A;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    wcfg_chk = 1'b1;
    n_cmp++;
    if (win_cfg !== 8'h8A) begin
      n_err++; $display("FAIL cfg_latched: got %h expected 8a", win_cfg);
    end
    for (int e = 3; e <= 70; e++) begin
      if (e == 6) cfg_window = 8'h55;
      win_err_overskip = (e == 10);
      set_hs(e == 13 || e == 33 || e == 53);
      step();
    end
    set_hs(1'b0);
    win_err_overskip = 1'b0;
    n_cmp++;
    if (wcfg_bad !== 0 || win_cfg !== 8'h8A) begin
      n_err++; $display("FAIL cfg_stable: got %0d bad cycles, final %h expected 0/8a", wcfg_bad, win_cfg);
    end
    n_cmp++;
    if (fd_at(0) !== 63 || sts_err !== 4'b0010) begin
      n_err++; $display("FAIL cfg_overskip_sticky: got frame_done at %0d sts_err=%b expected 63/0010",
                        fd_at(0), sts_err);
    end
  endtask

  task automatic test_stop_and_async_reset();
    do_reset();
    cfg_period = 32'd20; cfg_nchirp = 16'd3;
    start = 1'b1;
    step();
    for (int e = 2; e <= 24; e++) begin
      start = 1'b0;
      set_hs(e == 13);
      step();
    end
    set_hs(1'b0);
    n_cmp++;
    if (ramp !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL stop_pre: got ramp=%b busy=%b expected 1/1", ramp, busy);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_cmp++;
    if (ramp !== 1'b0 || busy !== 1'b0 || chirp_cnt !== 16'd1) begin
      n_err++; $display("FAIL stop_abort: got ramp=%b busy=%b chirp_cnt=%0d expected 0/0/1", ramp, busy, chirp_cnt);
    end
    for (int i = 0; i < 30; i++) step();
    n_cmp++;
    if (fds.size() !== 0 || busy !== 1'b0 || rises.size() !== 2) begin
      n_err++; $display("FAIL stop_quiet: got frame_done=%0d busy=%b rises=%0d expected 0/0/2",
                        fds.size(), busy, rises.size());
    end

    do_reset();
    cfg_window = 8'h8A; cfg_period = 32'd20; cfg_nchirp = 16'd3;
    start = 1'b1;
    step();
    for (int e = 2; e <= 24; e++) begin
      start = 1'b0;
      win_err_nsmall = (e == 10);
      set_hs(e == 13);
      step();
    end
    win_err_nsmall = 1'b0;
    set_hs(1'b0);
    n_cmp++;
    if (ramp !== 1'b1 || win_cfg !== 8'h8A || chirp_cnt !== 16'd1 || sts_err !== 4'b0001) begin
      n_err++; $display("FAIL areset_pre: got ramp=%b win_cfg=%h chirp_cnt=%0d sts_err=%b expected 1/8a/1/0001",
                        ramp, win_cfg, chirp_cnt, sts_err);
    end
    aresetn = 1'b0;
    #1;
    n_cmp++;
    if ({ramp, busy, frame_done} !== 3'b000 || win_cfg !== 8'h00 || chirp_cnt !== 16'd0 || sts_err !== 4'h0) begin
      n_err++; $display("FAIL areset_async: got ramp=%b busy=%b fd=%b win_cfg=%h chirp_cnt=%0d sts_err=%b expected all 0",
                        ramp, busy, frame_done, win_cfg, chirp_cnt, sts_err);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_missed_tlast();
    test_drain_timeout();
    test_bad_cfg();
    test_cfg_hold();
    test_stop_and_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_fmcw_chirp_sequencer.md
Name: axis_fmcw_chirp_sequencer

Overview:
Frame-level sequencer for the FMCW receive chain. It generates the periodic `ramp` trigger consumed by axis_fmcw_window and counts chirps per frame. It latches and holds the window config (`cfg_data` {skip, nfft}) stable for the whole frame. It monitors the window output stream for end-of-chirp `tlast` and collects the window error flags into sticky status for the PS.

Parameters:
PERIOD_WIDTH, 32, width of chirp period counter/config (cycles)
CHIRP_WIDTH, 16, width of chirps-per-frame config and counter
RAMP_LEN, 50, ramp pulse high time in aclk cycles (must be >=1)

Ports:
aclk  in  1  clock; all logic on rising edge
aresetn  in  1  reset; asynchronous, active-low
start  in  1  level, sampled each cycle; begins a frame when idle
stop  in  1  level, sampled each cycle; aborts a frame
cfg_period  in  PERIOD_WIDTH  ramp-to-ramp period, cycles
cfg_nchirp  in  CHIRP_WIDTH  chirps per frame
cfg_window  in  8  {skip[2:0], nfft[4:0]} for window block
win_err_nsmall  in  1  from window block
win_err_overskip  in  1  from window block
mon_tvalid  in  1  tap of window m_axis tvalid
mon_tready  in  1  tap of window m_axis tready
mon_tlast  in  1  tap of window m_axis tlast
ramp  out  1  chirp trigger to window block (registered)
win_cfg  out  8  cfg_data to window block (registered)
busy  out  1  high in any non-IDLE state
frame_done  out  1  one-cycle pulse at normal frame end
chirp_cnt  out  CHIRP_WIDTH  chirps whose period completed in current/last frame
sts_err  out  4  sticky: [0] nsmall, [1] overskip, [2] missed tlast, [3] bad cfg

Behaviour:
- Reset (async assert): state IDLE. All outputs 0: ramp, win_cfg=8'h00, busy, frame_done, chirp_cnt, sts_err. Internal period counter and pending flag are cleared.
- IDLE: ramp=0.
  - start=1 with cfg_period>RAMP_LEN and cfg_nchirp!=0 -> LOAD.
  - start=1 with bad config -> stay IDLE and set sts_err[3].
  - stop takes priority over start.
- LOAD (1 cycle):
  - win_cfg<=cfg_window; latch period and nchirp.
  - chirp_cnt<=0, sts_err<=0, pending<=0.
  - -> RUN with cnt=0.
  - win_cfg changes only in LOAD; cfg_* changes mid-frame have no effect.
- RUN:
  - cnt counts 0..period-1; ramp registered high for cnt in [0, RAMP_LEN-1]. First ramp cycle is the cycle after LOAD, so start sampled at edge N gives ramp high from edge N+2.
  - At cnt==period-1: chirp_cnt<=chirp_cnt+1. If chirp_cnt+1==nchirp -> DRAIN (cnt reset), else cnt<=0 (next ramp).
  - Consecutive ramp rising edges are exactly `period` cycles apart.
- Pending/missed tracking:
  - pending sets on each cnt==0 cycle in RUN.
  - pending clears on mon_tvalid&mon_tready&mon_tlast.
  - If pending is already set at cnt==0, set sts_err[2].
  - tlast handshake in the same cycle as cnt==0: clear takes effect first, so no miss is flagged and pending ends set.
- DRAIN:
  - ramp=0.
  - pending==0 (or tlast handshake this cycle) -> DONE.
  - cnt reaching period-1 with pending still set -> set sts_err[2], -> DONE.
- DONE (1 cycle): frame_done=1, busy=1 -> IDLE. chirp_cnt and sts_err hold until next LOAD.
- stop=1 in LOAD/RUN/DRAIN/DONE:
  - Next edge -> IDLE, ramp=0, no frame_done.
  - chirp_cnt and sts_err hold; win_cfg holds.
- start while busy is ignored (no restart).
- sts_err[0]/[1] OR in win_err_nsmall/win_err_overskip every cycle while busy (including DRAIN); inputs ignored in IDLE.
- chirp_cnt does not wrap within a frame (bounded by nchirp).
- cnt width is PERIOD_WIDTH; compares are unsigned.

Test Plan:
- Nominal frame, RAMP_LEN=4, period=20, nchirp=3, one tlast handshake 10 cycles after each ramp rise -> 3 ramp pulses, each 4 cycles, rises 20 apart. frame_done one cycle after DRAIN sees the 3rd tlast; chirp_cnt=3; sts_err=0; busy falls with return to IDLE.
- Chirp 1 tlast withheld, later chirps normal -> sts_err[2]=1 at the 2nd ramp rise. Frame continues: 3 ramps, frame_done asserted, chirp_cnt=3.
- No tlast after 3rd ramp -> DRAIN times out, frame_done 20 cycles after DRAIN entry, sts_err[2]=1.
- start with period=4 (<=RAMP_LEN), then start with nchirp=0 -> busy stays 0, ramp never rises, sts_err=4'b1000. Next valid start clears sts_err to 0 in LOAD.
- cfg_window=8'h8A at start, changed to 8'h55 mid-frame; overskip pulsed 1 cycle in RUN -> win_cfg stays 8'h8A all frame; sts_err[1]=1 and sticky after frame_done.
- stop asserted during the 2nd ramp pulse -> ramp 0 and busy 0 after next edge, no frame_done, chirp_cnt=1. aresetn dropped mid-RUN -> all outputs 0 immediately, without waiting for a clock edge.
